// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b datapath types for the memory stage: memory-op encoding,
// controller states and small decode helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_LDR,
        MOP_STR,
        MOP_LDB,
        MOP_STB,
        MOP_LDI,
        MOP_STI,
        MOP_TRAP
    } lc3b_memop;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PTR,
        S_ACC,
        S_DONE
    } mem_state_e;

    function automatic logic is_indirect(input lc3b_memop op);
        return (op == MOP_LDI) || (op == MOP_STI);
    endfunction

    function automatic logic is_store(input lc3b_memop op);
        return (op == MOP_STR) || (op == MOP_STB) || (op == MOP_STI);
    endfunction

    // Byte ops keep the raw address; everything else is word-aligned.
    function automatic lc3b_word access_addr(input lc3b_memop op, input lc3b_word addr);
        return ((op == MOP_LDB) || (op == MOP_STB)) ? addr : {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_byte_lane.sv
// Byte-lane steering for the memory stage: store byte enables / data
// replication and LDB byte extraction with zero extension.
module mem_byte_lane
    import lc3b_types::*;
(
    input  lc3b_memop     st_op,
    input  logic          st_addr0,
    input  lc3b_word      st_wdata,
    output lc3b_mem_wmask st_be,
    output lc3b_word      st_wdata_out,
    input  lc3b_memop     ld_op,
    input  logic          ld_addr0,
    input  lc3b_word      ld_rdata,
    output lc3b_word      ld_result
);

    always_comb begin
        st_be        = 2'b11;
        st_wdata_out = st_wdata;
        if (st_op == MOP_STB) begin
            st_be        = st_addr0 ? 2'b10 : 2'b01;
            st_wdata_out = {st_wdata[7:0], st_wdata[7:0]};
        end
    end

    always_comb begin
        ld_result = ld_rdata;
        if (ld_op == MOP_LDB) begin
            ld_result = ld_addr0 ? {8'h00, ld_rdata[15:8]} : {8'h00, ld_rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b memory-stage controller: sequences one or two data-memory handshakes
// per instruction (indirect pointer fetch, byte lanes) and stalls the pipeline.
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int unsigned RESP_TIMEOUT = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    input  lc3b_memop     req_op,
    input  lc3b_word      req_addr,
    input  lc3b_word      req_wdata,
    output logic          stall,
    output logic          done,
    output lc3b_word      rdata,
    output logic          err,
    output logic          dmem_read,
    output logic          dmem_write,
    output lc3b_word      dmem_address,
    output lc3b_word      dmem_wdata,
    output lc3b_mem_wmask dmem_byte_enable,
    input  logic          dmem_resp,
    input  lc3b_word      dmem_rdata
);

    localparam int unsigned TW   = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
    localparam int unsigned LAST = (RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0;

    mem_state_e    state;
    lc3b_memop     op_q;
    lc3b_word      addr_q;
    lc3b_word      wdata_q;
    logic [TW-1:0] tcount;

    logic          strobe;
    logic          timeout;
    lc3b_memop     lane_op;
    logic          lane_addr0;
    lc3b_word      lane_wdata_in;
    lc3b_word      lane_wdata;
    lc3b_mem_wmask lane_be;
    lc3b_word      ld_word;

    assign strobe  = dmem_read | dmem_write;
    assign timeout = (RESP_TIMEOUT != 0) && (tcount == TW'(LAST));

    assign stall = reset_n &
                   (((state != S_DONE) && req_valid && (req_op != MOP_NONE)) ||
                    (state == S_PTR) || (state == S_ACC));

    // In IDLE the lane sees the live request; afterwards only the latched copy.
    always_comb begin
        if (state == S_IDLE) begin
            lane_op       = req_op;
            lane_addr0    = req_addr[0];
            lane_wdata_in = req_wdata;
        end else begin
            lane_op       = op_q;
            lane_addr0    = addr_q[0];
            lane_wdata_in = wdata_q;
        end
    end

    mem_byte_lane u_lane (
        .st_op        (lane_op),
        .st_addr0     (lane_addr0),
        .st_wdata     (lane_wdata_in),
        .st_be        (lane_be),
        .st_wdata_out (lane_wdata),
        .ld_op        (op_q),
        .ld_addr0     (dmem_address[0]),
        .ld_rdata     (dmem_rdata),
        .ld_result    (ld_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            op_q             <= MOP_NONE;
            addr_q           <= '0;
            wdata_q          <= '0;
            tcount           <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
            rdata            <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= 2'b11;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && (req_op != MOP_NONE)) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        tcount  <= '0;
                        if (is_indirect(req_op)) begin
                            state            <= S_PTR;
                            dmem_read        <= 1'b1;
                            dmem_address     <= {req_addr[15:1], 1'b0};
                            dmem_byte_enable <= 2'b11;
                        end else begin
                            state            <= S_ACC;
                            dmem_read        <= ~is_store(req_op);
                            dmem_write       <= is_store(req_op);
                            dmem_address     <= access_addr(req_op, req_addr);
                            dmem_byte_enable <= lane_be;
                            dmem_wdata       <= lane_wdata;
                        end
                    end
                end

                S_PTR: begin
                    if (dmem_resp) begin
                        dmem_read <= 1'b0;
                        addr_q    <= dmem_rdata;
                        state     <= S_ACC;
                    end else if (timeout) begin
                        dmem_read <= 1'b0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end

                S_ACC: begin
                    // Entered from PTR with strobes low: issue the final access one cycle later.
                    if (!strobe) begin
                        tcount           <= '0;
                        dmem_read        <= ~is_store(op_q);
                        dmem_write       <= is_store(op_q);
                        dmem_address     <= access_addr(op_q, addr_q);
                        dmem_byte_enable <= lane_be;
                        dmem_wdata       <= lane_wdata;
                    end else if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (!is_store(op_q)) begin
                            rdata <= ld_word;
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (timeout) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        err        <= 1'b1;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table of single operations plus
// hand-written reset, idle and watchdog sequences against a word memory model.
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    lc3b_memop     req_op = MOP_NONE;
    logic [15:0]   req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic          stall, done, err, dmem_read, dmem_write;
    logic [15:0]   rdata, dmem_address, dmem_wdata;
    logic [1:0]    dmem_byte_enable;
    logic          dmem_resp = 1'b0;
    logic [15:0]   dmem_rdata = '0;

    mem_stage_ctrl #(.RESP_TIMEOUT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_op           (req_op),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .stall            (stall),
        .done             (done),
        .rdata            (rdata),
        .err              (err),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [int];
    int          ws = 0;
    int          wcnt = 0;
    logic        resp_en = 1'b1;
    int          log_n = 0;
    logic [15:0] first_addr, last_addr, last_wdata;
    logic [1:0]  last_be;
    logic        last_we;

    int          r_done, r_stall, r_rd, r_wr;
    logic        r_both;
    logic [15:0] r_rdata;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        int k;
        k = int'({a[15:1], 1'b0});
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: resp after ws wait states of a held strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_resp) begin
                dmem_resp = 1'b0;
            end else if (resp_en && reset_n && (dmem_read || dmem_write)) begin
                if (wcnt == ws) begin
                    wcnt = 0;
                    dmem_resp = 1'b1;
                    if (log_n == 0) first_addr = dmem_address;
                    log_n++;
                    last_addr  = dmem_address;
                    last_be    = dmem_byte_enable;
                    last_we    = dmem_write;
                    last_wdata = dmem_wdata;
                    if (dmem_read) dmem_rdata = mem_rd(dmem_address);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic run_op(input lc3b_memop op, input logic [15:0] addr, input logic [15:0] wd);
        int cyc;
        log_n   = 0;
        r_done  = -1;
        r_stall = 0;
        r_rd    = 0;
        r_wr    = 0;
        r_both  = 1'b0;
        r_rdata = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        cyc = 0;
        while (cyc < 40 && r_done < 0) begin
            #1;
            if (stall) r_stall++;
            if (dmem_read) r_rd++;
            if (dmem_write) r_wr++;
            if (dmem_read && dmem_write) r_both = 1'b1;
            if (done) begin
                r_done  = cyc;
                r_rdata = rdata;
            end
            @(negedge clk);
            cyc++;
            // Upstream changes while stalled must not affect the access.
            req_addr  = ~addr;
            req_wdata = ~wd;
        end
        req_valid = 1'b0;
        req_op    = MOP_NONE;
        #1;
        check("done one-shot", {31'd0, done}, 32'd0);
        check("stall after done", {31'd0, stall}, 32'd0);
    endtask

    typedef struct {
        lc3b_memop   op;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          ws;
        logic [15:0] e_paddr;
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic        e_we;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
        int          e_done;
        int          e_stall;
        int          e_rd;
        int          e_wr;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mem[int'(16'h3004)] = 16'hBEEF;
        mem[int'(16'h2000)] = 16'hA55A;
        mem[int'(16'h0046)] = 16'h1A2B;
        mem[int'(16'h4200)] = 16'h6007;
        mem[int'(16'h6006)] = 16'h7777;
        mem[int'(16'h4000)] = 16'h5002;

        //        op        addr      wdata    ws paddr     addr      be     we    wdata     rdata    done st rd wr
        vt[0] = '{MOP_LDR,  16'h3005, 16'h0000, 0, 16'h0000, 16'h3004, 2'b11, 1'b0, 16'h0000, 16'hBEEF, 2, 2, 1, 0};
        vt[1] = '{MOP_LDB,  16'h2001, 16'h0000, 0, 16'h0000, 16'h2001, 2'b11, 1'b0, 16'h0000, 16'h00A5, 2, 2, 1, 0};
        vt[2] = '{MOP_LDB,  16'h2000, 16'h0000, 0, 16'h0000, 16'h2000, 2'b11, 1'b0, 16'h0000, 16'h005A, 2, 2, 1, 0};
        vt[3] = '{MOP_STB,  16'h1000, 16'h12C3, 0, 16'h0000, 16'h1000, 2'b01, 1'b1, 16'hC3C3, 16'h005A, 2, 2, 0, 1};
        vt[4] = '{MOP_STB,  16'h1001, 16'h12C3, 0, 16'h0000, 16'h1001, 2'b10, 1'b1, 16'hC3C3, 16'h005A, 2, 2, 0, 1};
        vt[5] = '{MOP_STR,  16'h1235, 16'hCAFE, 0, 16'h0000, 16'h1234, 2'b11, 1'b1, 16'hCAFE, 16'h005A, 2, 2, 0, 1};
        vt[6] = '{MOP_TRAP, 16'h0046, 16'h0000, 0, 16'h0000, 16'h0046, 2'b11, 1'b0, 16'h0000, 16'h1A2B, 2, 2, 1, 0};
        vt[7] = '{MOP_LDI,  16'h4201, 16'h0000, 0, 16'h4200, 16'h6006, 2'b11, 1'b0, 16'h0000, 16'h7777, 4, 4, 2, 0};
        vt[8] = '{MOP_STI,  16'h4000, 16'h9ABC, 2, 16'h4000, 16'h5002, 2'b11, 1'b1, 16'h9ABC, 16'h7777, 8, 8, 3, 3};
        vt[9] = '{MOP_LDR,  16'h3004, 16'h0000, 3, 16'h0000, 16'h3004, 2'b11, 1'b0, 16'h0000, 16'hBEEF, 5, 5, 4, 0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        check("rst address", {16'd0, dmem_address}, 32'd0);
        check("rst wdata", {16'd0, dmem_wdata}, 32'd0);
        check("rst rdata", {16'd0, rdata}, 32'd0);
        check("rst byte_enable", {30'd0, dmem_byte_enable}, 32'd3);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ws = vt[i].ws;
            run_op(vt[i].op, vt[i].addr, vt[i].wdata);
            check($sformatf("v%0d done_cycle", i), r_done, vt[i].e_done);
            check($sformatf("v%0d stall_cycles", i), r_stall, vt[i].e_stall);
            check($sformatf("v%0d read_cycles", i), r_rd, vt[i].e_rd);
            check($sformatf("v%0d write_cycles", i), r_wr, vt[i].e_wr);
            check($sformatf("v%0d both_strobes", i), {31'd0, r_both}, 32'd0);
            check($sformatf("v%0d address", i), {16'd0, last_addr}, {16'd0, vt[i].e_addr});
            check($sformatf("v%0d byte_enable", i), {30'd0, last_be}, {30'd0, vt[i].e_be});
            check($sformatf("v%0d is_write", i), {31'd0, last_we}, {31'd0, vt[i].e_we});
            if (vt[i].e_we)
                check($sformatf("v%0d wdata", i), {16'd0, last_wdata}, {16'd0, vt[i].e_wdata});
            if (vt[i].e_paddr != 16'h0000)
                check($sformatf("v%0d ptr_address", i), {16'd0, first_addr}, {16'd0, vt[i].e_paddr});
            check($sformatf("v%0d rdata", i), {16'd0, r_rdata}, {16'd0, vt[i].e_rdata});
            check($sformatf("v%0d err", i), {31'd0, err}, 32'd0);
        end
        ws = 0;

        // MOP_NONE and invalid requests start nothing
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MOP_NONE;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("none stall", {31'd0, stall}, 32'd0);
            check("none strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        req_op    = MOP_LDR;
        #1;
        check("invalid stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        check("invalid strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        req_op = MOP_NONE;

        // Reset while the final access strobe is up
        resp_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MOP_LDR;
        req_addr  = 16'h3005;
        @(negedge clk);
        #1;
        check("mid strobe up", {31'd0, dmem_read}, 32'd1);
        check("mid stall up", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid rst read", {31'd0, dmem_read}, 32'd0);
        check("mid rst write", {31'd0, dmem_write}, 32'd0);
        check("mid rst stall", {31'd0, stall}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst address", {16'd0, dmem_address}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = MOP_NONE;
        reset_n   = 1'b1;
        resp_en   = 1'b1;
        wcnt      = 0;
        run_op(MOP_LDR, 16'h3005, 16'h0000);
        check("post rst done_cycle", r_done, 2);
        check("post rst rdata", {16'd0, r_rdata}, 32'h0000BEEF);
        check("post rst address", {16'd0, last_addr}, 32'h00003004);

        // Watchdog: no response at all
        resp_en = 1'b0;
        run_op(MOP_LDR, 16'h3004, 16'h0000);
        check("wd read_cycles", r_rd, 4);
        check("wd done_cycle", r_done, 5);
        check("wd stall_cycles", r_stall, 5);
        check("wd responses", log_n, 0);
        check("wd err", {31'd0, err}, 32'd1);
        check("wd rdata kept", {16'd0, r_rdata}, 32'h0000BEEF);
        check("wd strobes low", {30'd0, dmem_read, dmem_write}, 32'd0);

        // err is sticky across a normal access, cleared by reset
        resp_en = 1'b1;
        run_op(MOP_STR, 16'h1000, 16'h0F0F);
        check("sticky done_cycle", r_done, 2);
        check("sticky err", {31'd0, err}, 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("err cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage access controller for the LC-3b pipeline. It sits between the EX/MEM pipeline register and the data-memory port.
- It takes one memory operation per instruction: LDR, STR, LDB, STB, LDI, STI or TRAP vector fetch.
- It sequences one or two memory handshakes, handles byte lanes and indirection, and stalls the pipeline until the access completes.
- It hands the loaded word to the MEM/WB register.

Parameters:
- RESP_TIMEOUT, 0, cycles to wait for dmem_resp per access before raising err; 0 disables the watchdog.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX/MEM holds a valid instruction
- req_op  in  3  lc3b_memop: MOP_NONE, MOP_LDR, MOP_STR, MOP_LDB, MOP_STB, MOP_LDI, MOP_STI, MOP_TRAP
- req_addr  in  16  effective address (TRAP: zext(trapvect8)<<1, computed upstream)
- req_wdata  in  16  store data (SR value)
- stall  out  1  freeze PC, DE, EX/MEM; bubble into MEM/WB
- done  out  1  one-cycle pulse; access complete, rdata valid
- rdata  out  16  load result (LDB zero-extended); held until next done
- err  out  1  sticky timeout flag; cleared only by reset
- dmem_read  out  1  memory read strobe
- dmem_write  out  1  memory write strobe
- dmem_address  out  16  memory address
- dmem_wdata  out  16  memory write data
- dmem_byte_enable  out  2  lc3b_mem_wmask, bit1 = high byte
- dmem_resp  in  1  memory response, one-cycle pulse
- dmem_rdata  in  16  read data, valid with dmem_resp

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state=IDLE.
  - stall, done, err, dmem_read, dmem_write = 0.
  - dmem_address, dmem_wdata, rdata = 0.
  - dmem_byte_enable = 2'b11.
  - Timeout counter = 0.
- States: IDLE, PTR (indirect pointer read), ACC (final access), DONE.
- IDLE:
  - req_valid=0 or op=MOP_NONE: no access, stall=0.
  - Otherwise (accept cycle T): stall=1 combinationally.
  - Next state: PTR for LDI/STI, else ACC. Address and strobes are registered at the T edge.
- Strobes are registered outputs. They are asserted from T+1 and held stable until the cycle dmem_resp=1 is sampled, then deasserted.
- PTR:
  - dmem_read=1, address = {req_addr[15:1],0}, byte_enable=11.
  - On resp: latch dmem_rdata as pointer, go to ACC.
  - ACC address = {ptr[15:1],0}. LDI reads; STI writes req_wdata, byte_enable=11.
- ACC addressing:
  - LDR/STR/LDI/STI/TRAP: address bit0 forced 0, byte_enable=11.
  - LDB/STB: address = req_addr unaligned.
  - STB: byte_enable = req_addr[0] ? 10 : 01; wdata = {req_wdata[7:0], req_wdata[7:0]}.
- On resp in ACC:
  - Loads: rdata = dmem_rdata. For LDB the value is zext of byte [15:8] if addr[0]=1, else [7:0].
  - Stores: rdata unchanged.
  - Next state DONE.
- DONE:
  - done=1, stall=0; the pipeline advances on this edge.
  - Next state IDLE. The request is not re-sampled in DONE, so no double access occurs.
- stall = (state≠DONE) & req_valid & op≠MOP_NONE, plus (state∈{PTR,ACC}).
- Latency with zero-wait memory (resp the first cycle a strobe is up):
  - Single access: accept T, strobe T+1, done T+2. stall is high T..T+1.
  - Indirect: done T+4.
- dmem_resp in IDLE or DONE: ignored.
- dmem_read and dmem_write are never both 1.
- req_* are sampled only at accept. Changes while stalled are ignored; the PTR and ACC addresses come from registered copies.
- Watchdog (RESP_TIMEOUT=N>0):
  - The counter resets on each strobe assertion.
  - After N strobe cycles without resp: err=1, strobes drop, go to DONE. done pulses with rdata unchanged.

Decomposition:
- lc3b_types package:
  - lc3b_memop enum and state enum.
  - lc3b_mem_wmask, lc3b_word (existing).
- Sub-module mem_byte_lane: combinational.
  - Store side: addr[0], op → byte_enable, wdata replication.
  - Load side: LDB extract/zero-extend.
- FSM, request latches and watchdog stay in mem_stage_ctrl.

Test Plan:
- LDR, req_addr=0x3005, memory[0x3004]=0xBEEF, resp at first strobe:
  - dmem_address=0x3004, read 1 cycle, byte_enable=11.
  - done at T+2, rdata=0xBEEF, stall high exactly 2 cycles.
- LDB, addr=0x2001, dmem_rdata=0xA55A → rdata=0x00A5. Same with addr=0x2000 → rdata=0x005A.
- STB, addr=0x1000, req_wdata=0x12C3 → dmem_write=1, byte_enable=01, dmem_wdata=0xC3C3, dmem_read=0.
- STI, addr=0x4000, memory[0x4000]=0x5002, 2 wait states per access:
  - Read at 0x4000, then write 0x5002 with wdata passed through.
  - done once, at T+8.
- Reset asserted while ACC strobe is up → strobes, stall, done drop the same cycle. After release, a new LDR completes normally.
- RESP_TIMEOUT=4, no dmem_resp → strobe held 4 cycles then dropped, err=1 sticky, done pulses once, stall releases.
